mem_arb: RTL and testbench
==========================

Name: mem_arb

Overview:
Arbiter and sequencer that shares one word-wide backing-memory port between the instruction-cache refill path and the data-cache refill/writeback path. It sits between the two caches and main memory. Each won request is run as a LINE_WORDS-beat burst, one word per beat. The per-cache busy signals that stall fetch and decode are held by the caches until this block signals done.

Parameters:
LINE_WORDS, 4, words per cache line and beats per burst (power of 2, at least 2)
BEAT_W, 2, width of the beat counter; equals log2(LINE_WORDS)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_ic_req  in  1  icache line-read request; level, held until o_ic_done
i_ic_addr  in  32  icache miss address; low log2(LINE_WORDS)+2 bits ignored
o_ic_gnt  out  1  icache owns the memory port (level, whole burst)
o_ic_rvld  out  1  read beat valid to icache
o_ic_rdata  out  32  read beat data
o_ic_done  out  1  one-cycle pulse: last icache beat complete
i_dc_req  in  1  dcache request; level, held until o_dc_done
i_dc_we  in  1  1 = line writeback, 0 = line read; sampled at grant
i_dc_addr  in  32  dcache line address; low bits ignored
i_dc_wdata  in  32  write word for the current beat
o_dc_wnext  out  1  current write beat accepted; dcache advances i_dc_wdata next cycle
o_dc_gnt  out  1  dcache owns the port
o_dc_rvld  out  1  read beat valid to dcache
o_dc_rdata  out  32  read beat data
o_dc_done  out  1  one-cycle pulse: last dcache beat complete
o_beat  out  BEAT_W  index of the current beat
o_mem_ren  out  1  word read command
o_mem_wen  out  1  word write command
o_mem_addr  out  32  word address
o_mem_wdata  out  32  write data
i_mem_ready  in  1  command accepted this cycle
i_mem_rvalid  in  1  read data valid; in order, one per accepted read
i_mem_rdata  in  32  read data

Behaviour:
- States: IDLE, RD_CMD, RD_DATA, WR, GAP.
- Reset: state IDLE, beat 0, base address 0, owner none, last_owner = IC (so the first tie goes to dcache). All outputs are 0.
- IDLE, arbitration:
  - Only icache requesting: grant IC. Only dcache requesting: grant DC.
  - Both requesting: grant the requester that is not last_owner (round-robin).
  - On grant, register: base = addr with low bits cleared, owner, write flag (i_dc_we for DC, 0 for IC), beat = 0.
  - Next state: WR if write flag is set, else RD_CMD. Arbitration costs one cycle; a request seen at edge t issues its first command at t+1.
- Address: o_mem_addr = base | (beat << 2).
- o_ic_gnt / o_dc_gnt: high in every non-IDLE state while that requester is owner.
- RD_CMD:
  - o_mem_ren = 1.
  - i_mem_ready = 1: go to RD_DATA. Otherwise hold; address is stable.
- RD_DATA:
  - o_mem_ren = 0. Wait for i_mem_rvalid.
  - On rvalid: the owner's rvld = 1 and its rdata = i_mem_rdata, same cycle (combinational).
  - Not last beat: beat+1, return to RD_CMD.
  - Last beat: owner's done = 1 the same cycle, go to GAP.
  - Only one read is outstanding at a time.
- WR:
  - o_mem_wen = 1, o_mem_wdata = i_dc_wdata.
  - On i_mem_ready: o_dc_wnext = 1. If not last beat, beat+1 and stay in WR. If last beat, o_dc_done = 1 and go to GAP.
- GAP:
  - Lasts one cycle. Requests are ignored; beat clears to 0; last_owner = owner; owner clears.
  - Then go to IDLE.
  - Requesters must deassert req in the cycle after done; GAP guarantees a stale req is never re-granted.
- No preemption: a burst always completes once granted.
- i_mem_rvalid is ignored outside RD_DATA. i_mem_ready is ignored outside RD_CMD/WR.
- rdata outputs may show i_mem_rdata at any time; only rvld is qualified.
- Reset mid-burst: abandon the burst; all outputs 0 on the next cycle; no done pulse is issued.
- Requester address or we changing mid-burst has no effect; values are captured at grant.
- Beat counter wraps only via GAP; it never exceeds LINE_WORDS-1.

Test Plan:
- Icache read, i_ic_addr = 0x0000_010C, memory ready immediately, rvalid 2 cycles after accept -> ren addresses 0x100, 0x104, 0x108, 0x10C; four o_ic_rvld pulses; o_ic_done with the 4th; o_ic_gnt low 2 cycles after done.
- i_ic_req and i_dc_req (read, 0x200) both rise the cycle after reset -> dcache served first (0x200..0x20C); icache served next with no other request granted in between; o_dc_gnt and o_ic_gnt never high together.
- Dcache requests back-to-back while icache stays pending -> order DC, IC, DC (round-robin; no starvation).
- Dcache writeback to 0x300, data 0xA0..0xA3, i_mem_ready low 3 cycles on beat 1 -> o_mem_addr/o_mem_wdata held at 0x304/0xA1 through the stall; exactly 4 o_dc_wnext pulses; o_dc_done on the 4th.
- i_rst asserted during beat 2 of an icache read -> next cycle all outputs 0, state IDLE, no o_ic_done; a following dcache request is granted normally.
- Spurious i_mem_rvalid in IDLE or RD_CMD -> no rvld pulse; beat unchanged.

Source files
------------

// File: rtl/mem_arb.sv
// mem_arb: shares one word-wide backing-memory port between the icache refill
// path and the dcache refill/writeback path.  Each granted request runs as a
// LINE_WORDS-beat burst, one word per beat, followed by a one-cycle GAP so a
// requester that is still dropping its level request is never re-granted.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_ic_req/i_ic_addr      icache line-read request and miss address
//   o_ic_gnt/rvld/rdata     icache ownership, read beat strobe and data
//   o_ic_done               one-cycle pulse with the last icache beat
//   i_dc_req/we/addr/wdata  dcache request, direction, line address, write word
//   o_dc_wnext              current write beat accepted by memory
//   o_dc_gnt/rvld/rdata     dcache ownership, read beat strobe and data
//   o_dc_done               one-cycle pulse with the last dcache beat
//   o_beat                  index of the current beat
//   o_mem_*/i_mem_*         word-wide memory command/response port
module mem_arb #(
    parameter int LINE_WORDS = 4,
    parameter int BEAT_W     = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ic_req,
    input  logic [31:0]       i_ic_addr,
    output logic              o_ic_gnt,
    output logic              o_ic_rvld,
    output logic [31:0]       o_ic_rdata,
    output logic              o_ic_done,
    input  logic              i_dc_req,
    input  logic              i_dc_we,
    input  logic [31:0]       i_dc_addr,
    input  logic [31:0]       i_dc_wdata,
    output logic              o_dc_wnext,
    output logic              o_dc_gnt,
    output logic              o_dc_rvld,
    output logic [31:0]       o_dc_rdata,
    output logic              o_dc_done,
    output logic [BEAT_W-1:0] o_beat,
    output logic              o_mem_ren,
    output logic              o_mem_wen,
    output logic [31:0]       o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_ready,
    input  logic              i_mem_rvalid,
    input  logic [31:0]       i_mem_rdata
);

    // Byte-offset bits inside one line; cleared when the base is captured.
    localparam logic [31:0] LINE_MASK = {{(30 - BEAT_W){1'b0}}, {(BEAT_W + 2){1'b1}}};
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_CMD,
        S_RD_DATA,
        S_WR,
        S_GAP
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IC,
        OWN_DC
    } owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [31:0]       base_q, base_d;
    logic              last_dc_q, last_dc_d;   // 1: dcache owned the previous burst

    logic gnt_dc;
    logic gnt_ic;
    logic last_beat;
    logic rd_beat;

    // Round-robin tie break: on a tie the dcache wins unless it had the port last.
    assign gnt_dc    = i_dc_req && (!i_ic_req || !last_dc_q);
    assign gnt_ic    = i_ic_req && !gnt_dc;
    assign last_beat = (beat_q == LAST_BEAT);
    assign rd_beat   = (state_q == S_RD_DATA) && i_mem_rvalid;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            owner_q   <= OWN_NONE;
            beat_q    <= '0;
            base_q    <= '0;
            last_dc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            beat_q    <= beat_d;
            base_q    <= base_d;
            last_dc_q <= last_dc_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        beat_d    = beat_q;
        base_d    = base_q;
        last_dc_d = last_dc_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_dc) begin
                    owner_d = OWN_DC;
                    base_d  = i_dc_addr & ~LINE_MASK;
                    beat_d  = '0;
                    // The write flag is carried by the state itself.
                    state_d = i_dc_we ? S_WR : S_RD_CMD;
                end else if (gnt_ic) begin
                    owner_d = OWN_IC;
                    base_d  = i_ic_addr & ~LINE_MASK;
                    beat_d  = '0;
                    state_d = S_RD_CMD;
                end
            end
            S_RD_CMD: begin
                if (i_mem_ready) begin
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                // Single outstanding read: the next command waits for this data.
                if (i_mem_rvalid) begin
                    if (last_beat) begin
                        state_d = S_GAP;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        state_d = S_RD_CMD;
                    end
                end
            end
            S_WR: begin
                if (i_mem_ready) begin
                    if (last_beat) begin
                        state_d = S_GAP;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            S_GAP: begin
                beat_d    = '0;
                last_dc_d = (owner_q == OWN_DC);
                owner_d   = OWN_NONE;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
                beat_d  = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        o_ic_gnt    = 1'b0;
        o_dc_gnt    = 1'b0;
        o_ic_rvld   = 1'b0;
        o_dc_rvld   = 1'b0;
        o_ic_rdata  = '0;
        o_dc_rdata  = '0;
        o_ic_done   = 1'b0;
        o_dc_done   = 1'b0;
        o_dc_wnext  = 1'b0;
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_wdata = '0;
        o_beat      = beat_q;
        o_mem_addr  = base_q | (32'(beat_q) << 2);

        if (state_q != S_IDLE) begin
            o_ic_gnt = (owner_q == OWN_IC);
            o_dc_gnt = (owner_q == OWN_DC);
        end

        case (state_q)
            S_RD_CMD: begin
                o_mem_ren = 1'b1;
            end
            S_RD_DATA: begin
                // Read data is forwarded combinationally in the cycle it arrives.
                if (rd_beat) begin
                    if (owner_q == OWN_IC) begin
                        o_ic_rvld  = 1'b1;
                        o_ic_rdata = i_mem_rdata;
                        o_ic_done  = last_beat;
                    end else if (owner_q == OWN_DC) begin
                        o_dc_rvld  = 1'b1;
                        o_dc_rdata = i_mem_rdata;
                        o_dc_done  = last_beat;
                    end
                end
            end
            S_WR: begin
                o_mem_wen   = 1'b1;
                o_mem_wdata = i_dc_wdata;
                if (i_mem_ready) begin
                    o_dc_wnext = 1'b1;
                    o_dc_done  = last_beat;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arb.sv
module tb_mem_arb;

    logic        clk;
    logic        i_rst;
    logic        i_ic_req;
    logic [31:0] i_ic_addr;
    logic        o_ic_gnt, o_ic_rvld, o_ic_done;
    logic [31:0] o_ic_rdata;
    logic        i_dc_req, i_dc_we;
    logic [31:0] i_dc_addr, i_dc_wdata;
    logic        o_dc_wnext, o_dc_gnt, o_dc_rvld, o_dc_done;
    logic [31:0] o_dc_rdata;
    logic [1:0]  o_beat;
    logic        o_mem_ren, o_mem_wen;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic        i_mem_ready, i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    mem_arb #(.LINE_WORDS(4), .BEAT_W(2)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_ic_req(i_ic_req), .i_ic_addr(i_ic_addr),
        .o_ic_gnt(o_ic_gnt), .o_ic_rvld(o_ic_rvld), .o_ic_rdata(o_ic_rdata), .o_ic_done(o_ic_done),
        .i_dc_req(i_dc_req), .i_dc_we(i_dc_we), .i_dc_addr(i_dc_addr), .i_dc_wdata(i_dc_wdata),
        .o_dc_wnext(o_dc_wnext), .o_dc_gnt(o_dc_gnt), .o_dc_rvld(o_dc_rvld), .o_dc_rdata(o_dc_rdata),
        .o_dc_done(o_dc_done), .o_beat(o_beat),
        .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Memory-side drive: table values in the table phase, a small memory model afterwards.
    logic        model_en = 1'b0;
    logic        tbl_ready = 1'b0, tbl_rvalid = 1'b0;
    logic [31:0] tbl_rdata = '0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          stall_used = 0;
    int          stall_limit = 0;
    logic [31:0] stall_addr = 32'h304;
    logic        mdl_ready;

    // Memory model: reads return 0xD000_0000|addr one cycle after acceptance;
    // writes to stall_addr are refused for stall_limit cycles.
    assign mdl_ready    = !((stall_used < stall_limit) && o_mem_wen && (o_mem_addr == stall_addr));
    assign i_mem_ready  = model_en ? mdl_ready : tbl_ready;
    assign i_mem_rvalid = model_en ? pend : tbl_rvalid;
    assign i_mem_rdata  = model_en ? (pend ? (32'hD000_0000 | pend_addr) : 32'h0) : tbl_rdata;

    always @(posedge clk) begin
        pend      <= o_mem_ren && i_mem_ready;
        pend_addr <= o_mem_addr;
        if (model_en && !mdl_ready) stall_used <= stall_used + 1;
    end

    // Monitor: logs grants, accepted commands and strobes for the sequence checks.
    logic        prev_ic = 1'b0, prev_dc = 1'b0;
    int          gq[$];
    logic [31:0] raddr_q[$], waddr_q[$], wdat_q[$], ic_data_q[$], dc_data_q[$];
    int overlap_cnt = 0, wnext_cnt = 0, ic_done_cnt = 0, dc_done_cnt = 0;
    int done_wnext = 0, stall_cyc = 0, stall_hold = 0;

    always @(negedge clk) begin
        prev_ic <= o_ic_gnt;
        prev_dc <= o_dc_gnt;
        if (model_en) begin
            if (o_ic_gnt && o_dc_gnt) overlap_cnt <= overlap_cnt + 1;
            if (o_dc_gnt && !prev_dc) gq.push_back(1);
            if (o_ic_gnt && !prev_ic) gq.push_back(0);
            if (o_mem_ren && i_mem_ready) raddr_q.push_back(o_mem_addr);
            if (o_ic_rvld) ic_data_q.push_back(o_ic_rdata);
            if (o_dc_rvld) dc_data_q.push_back(o_dc_rdata);
            if (o_mem_wen && i_mem_ready) begin
                waddr_q.push_back(o_mem_addr);
                wdat_q.push_back(o_mem_wdata);
            end
            if (o_mem_wen && !i_mem_ready) begin
                stall_cyc <= stall_cyc + 1;
                if (o_mem_addr == 32'h304 && o_mem_wdata == 32'hA1) stall_hold <= stall_hold + 1;
            end
            if (o_dc_wnext) wnext_cnt <= wnext_cnt + 1;
            if (o_ic_done) ic_done_cnt <= ic_done_cnt + 1;
            if (o_dc_done) begin
                dc_done_cnt <= dc_done_cnt + 1;
                if (o_dc_wnext) done_wnext <= done_wnext + 1;
            end
        end
    end

    typedef struct {
        logic        ic_req;
        logic        rdy;
        logic        rvalid;
        logic [31:0] rdata;
        logic [8:0]  flags;   // ic_gnt ren ic_rvld ic_done dc_gnt wen dc_rvld dc_done dc_wnext
        logic [31:0] addr;
        logic [1:0]  beat;
    } vec_t;

    vec_t vecs[16];

    task automatic do_reset();
        i_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 i_rst = 1'b0;
    endtask

    // Holds the icache request until done, then drops it for the GAP cycle.
    task automatic run_ic(input string tag, input logic [31:0] addr);
        logic seen;
        seen = 1'b0;
        i_ic_addr = addr;
        i_ic_req  = 1'b1;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            seen = o_ic_done;
            @(posedge clk);
            #1;
        end
        i_ic_req = 1'b0;
        chk({tag, "_ic_done_seen"}, 32'(seen), 32'd1);
    endtask

    // Dcache requester: presents write word idx, advancing on each wnext.
    task automatic run_dc(input string tag, input logic we, input logic [31:0] addr, input logic [127:0] wd);
        logic seen;
        int   idx;
        seen = 1'b0;
        idx  = 0;
        i_dc_we    = we;
        i_dc_addr  = addr;
        i_dc_wdata = wd[31:0];
        i_dc_req   = 1'b1;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            seen = o_dc_done;
            if (o_dc_wnext && idx < 3) idx++;
            @(posedge clk);
            #1;
            i_dc_wdata = wd[idx*32 +: 32];
        end
        i_dc_req = 1'b0;
        chk({tag, "_dc_done_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g0, r0, d0, w0, c0, s0, h0, dw0, dd0, ic0;
        logic found;

        i_rst = 1'b1;
        i_ic_req = 0; i_ic_addr = 32'h10C;
        i_dc_req = 0; i_dc_we = 0; i_dc_addr = 0; i_dc_wdata = 0;

        // Icache read of 0x10C: per-cycle trace with a stalled command and spurious rvalids.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 32'hDEAD0000, 9'b000000000, 32'h000, 2'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,        9'b110000000, 32'h100, 2'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        9'b100000000, 32'h100, 2'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h000000D0, 9'b101000000, 32'h100, 2'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h00000BAD, 9'b110000000, 32'h104, 2'd1};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,        9'b110000000, 32'h104, 2'd1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,        9'b100000000, 32'h104, 2'd1};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h000000D1, 9'b101000000, 32'h104, 2'd1};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,        9'b110000000, 32'h108, 2'd2};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,        9'b100000000, 32'h108, 2'd2};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h000000D2, 9'b101000000, 32'h108, 2'd2};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h0,        9'b110000000, 32'h10C, 2'd3};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0,        9'b100000000, 32'h10C, 2'd3};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 32'h000000D3, 9'b101100000, 32'h10C, 2'd3};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        9'b100000000, 32'h10C, 2'd3};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,        9'b000000000, 32'h100, 2'd0};

        do_reset();
        // Reset state with nothing requesting
        @(negedge clk);
        chk("reset_flags", 32'({o_ic_gnt, o_mem_ren, o_ic_rvld, o_ic_done, o_dc_gnt, o_mem_wen,
                                o_dc_rvld, o_dc_done, o_dc_wnext, o_beat}), 32'd0);
        chk("reset_addr", o_mem_addr, 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            i_ic_req   = vecs[i].ic_req;
            tbl_ready  = vecs[i].rdy;
            tbl_rvalid = vecs[i].rvalid;
            tbl_rdata  = vecs[i].rdata;
            @(negedge clk);
            chk($sformatf("row%0d_flags", i),
                32'({o_ic_gnt, o_mem_ren, o_ic_rvld, o_ic_done, o_dc_gnt, o_mem_wen,
                     o_dc_rvld, o_dc_done, o_dc_wnext}), 32'(vecs[i].flags));
            chk($sformatf("row%0d_addr", i), o_mem_addr, vecs[i].addr);
            chk($sformatf("row%0d_beat", i), 32'(o_beat), 32'(vecs[i].beat));
            if (vecs[i].flags[6]) chk($sformatf("row%0d_ic_rdata", i), o_ic_rdata, vecs[i].rdata);
            @(posedge clk);
            #1;
        end
        tbl_ready = 0; tbl_rvalid = 0; tbl_rdata = 0;

        // Simultaneous requests right after reset: dcache first, then icache.
        model_en = 1'b1;
        do_reset();
        g0 = gq.size(); r0 = raddr_q.size(); d0 = dc_data_q.size(); ic0 = ic_data_q.size();
        c0 = overlap_cnt;
        fork
            run_ic("t2", 32'h104);
            run_dc("t2", 1'b0, 32'h200, 128'h0);
        join
        repeat (2) @(posedge clk);
        #1;
        chk("t2_grants", 32'(gq.size() - g0), 32'd2);
        if (gq.size() >= g0 + 2) begin
            chk("t2_first_dc", 32'(gq[g0]), 32'd1);
            chk("t2_second_ic", 32'(gq[g0+1]), 32'd0);
        end
        chk("t2_reads", 32'(raddr_q.size() - r0), 32'd8);
        for (int k = 0; k < 8 && r0 + k < raddr_q.size(); k++)
            chk($sformatf("t2_raddr%0d", k), raddr_q[r0+k],
                (k < 4) ? (32'h200 + 32'(4*k)) : (32'h100 + 32'(4*(k-4))));
        if (dc_data_q.size() > d0) chk("t2_dc_data0", dc_data_q[d0], 32'hD000_0200);
        if (ic_data_q.size() > ic0 + 3) chk("t2_ic_data3", ic_data_q[ic0+3], 32'hD000_010C);
        chk("t2_no_overlap", 32'(overlap_cnt - c0), 32'd0);

        // Dcache back-to-back with icache pending: DC, IC, DC.
        g0 = gq.size();
        fork
            run_ic("t3", 32'h400);
            begin
                run_dc("t3a", 1'b0, 32'h500, 128'h0);
                @(posedge clk);
                #1;
                run_dc("t3b", 1'b0, 32'h600, 128'h0);
            end
        join
        repeat (2) @(posedge clk);
        #1;
        chk("t3_grants", 32'(gq.size() - g0), 32'd3);
        if (gq.size() >= g0 + 3)
            chk("t3_order", 32'({gq[g0][1:0], gq[g0+1][1:0], gq[g0+2][1:0]}), 32'b01_00_01);
        chk("t3_no_overlap", 32'(overlap_cnt - c0), 32'd0);

        // Writeback to 0x300 with beat 1 refused for three cycles.
        w0 = waddr_q.size(); s0 = stall_cyc; h0 = stall_hold; dw0 = done_wnext;
        dd0 = dc_done_cnt; c0 = wnext_cnt;
        stall_limit = stall_used + 3;
        run_dc("t4", 1'b1, 32'h300, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        repeat (2) @(posedge clk);
        #1;
        chk("t4_writes", 32'(waddr_q.size() - w0), 32'd4);
        for (int k = 0; k < 4 && w0 + k < waddr_q.size(); k++) begin
            chk($sformatf("t4_waddr%0d", k), waddr_q[w0+k], 32'h300 + 32'(4*k));
            chk($sformatf("t4_wdata%0d", k), wdat_q[w0+k], 32'hA0 + 32'(k));
        end
        chk("t4_wnext_cnt", 32'(wnext_cnt - c0), 32'd4);
        chk("t4_stall_cycles", 32'(stall_cyc - s0), 32'd3);
        chk("t4_stall_held", 32'(stall_hold - h0), 32'd3);
        chk("t4_done_cnt", 32'(dc_done_cnt - dd0), 32'd1);
        chk("t4_done_with_wnext", 32'(done_wnext - dw0), 32'd1);

        // Reset during beat 2 of an icache read.
        ic0 = ic_done_cnt;
        found = 1'b0;
        i_ic_addr = 32'h800;
        i_ic_req  = 1'b1;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            found = o_ic_gnt && (o_beat == 2'd2);
            @(posedge clk);
            #1;
        end
        chk("t5_beat2_reached", 32'(found), 32'd1);
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        i_ic_req = 1'b0;
        @(negedge clk);
        chk("t5_flags_zero", 32'({o_ic_gnt, o_mem_ren, o_ic_rvld, o_ic_done, o_dc_gnt, o_mem_wen,
                                  o_dc_rvld, o_dc_done, o_dc_wnext, o_beat}), 32'd0);
        chk("t5_addr_zero", o_mem_addr, 32'h0);
        chk("t5_data_zero", o_ic_rdata | o_dc_rdata | o_mem_wdata, 32'h0);
        chk("t5_no_ic_done", 32'(ic_done_cnt - ic0), 32'd0);
        @(posedge clk);
        #1;
        g0 = gq.size(); r0 = raddr_q.size();
        run_dc("t5", 1'b0, 32'h704, 128'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("t5_dc_granted", 32'(gq.size() - g0), 32'd1);
        if (raddr_q.size() > r0) chk("t5_dc_raddr0", raddr_q[r0], 32'h700);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
